simd_wb_queue: RTL and testbench

//  Downstream neighbour of the SIMD integer unit. Tracks each issued SIMD op's destination tag through the

---
 rtl/simd_wb_pkg.sv | 20 ++
 rtl/simd_wb_fifo.sv | 72 +++++++
 rtl/simd_wb_queue.sv | 110 +++++++++++
 tb/tb_simd_wb_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_wb_pkg.sv
// Shared types for the SIMD writeback queue: result layout, queue entry and unit latency.
package simd_wb_pkg;

  localparam int SIMD_LAT   = 2;
  localparam int SIMD_TAG_W = 9;

  typedef struct packed {
    logic [1:0]  ptype;
    logic        pad1;
    logic [31:0] hi;
    logic        pad0;
    logic [31:0] lo;
  } simd_res_t;

  typedef struct packed {
    logic [SIMD_TAG_W-1:0] tag;
    simd_res_t             res;
  } wb_entry_t;

endpackage

// File: rtl/simd_wb_fifo.sv
// DEPTH-entry synchronous FIFO with flush; exposes the next-cycle count for credit tracking.
module simd_wb_fifo
  import simd_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = SIMD_TAG_W + $bits(simd_res_t),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head       = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/simd_wb_queue.sv
// Tracks SIMD op tags through the unit latency, queues results for writeback and throttles issue.
// Optional SIMD_WB_BYPASS_EN: an arrival into an empty queue is presented on wb_* the same cycle.
module simd_wb_queue
  import simd_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = SIMD_TAG_W,
  parameter int LAT   = SIMD_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_en,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             issue_stall,
  input  logic [67:0]      simd_res,
  input  logic             flush,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [67:0]      wb_data,
  output logic             ovf_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = TAG_W + $bits(simd_res_t);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Valid/ready: an entry transfers on any cycle where wb_valid and wb_ready are both high.
  logic [LAT-1:0]   vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [LAT];
  logic [TAG_W-1:0] tag_d [LAT];
  logic             issue_stall_q, issue_stall_d;
  logic             ovf_err_q, ovf_err_d;
  logic [CNT_W-1:0] count, count_next;
  logic [ENT_W-1:0] head;
  logic [TAG_W-1:0] arr_tag;
  simd_res_t        arr_res;
  logic             arrival, bypass, fifo_full, push, pop;

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    for (int i = LAT - 1; i > 0; i--) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    vld_d[0] = issue_en;
    tag_d[0] = issue_tag;
    if (flush) begin
      vld_d = '0;
    end
  end

  assign arrival   = vld_q[LAT-1];
  assign arr_tag   = tag_q[LAT-1];
  assign arr_res   = simd_res;
  assign fifo_full = (count == FULL_CNT);

`ifdef SIMD_WB_BYPASS_EN
  assign bypass = arrival & (count == '0) & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign wb_valid         = (count != '0) | bypass;
  assign {wb_tag, wb_data} = bypass ? {arr_tag, arr_res} : head;
  assign pop              = (count != '0) & wb_ready;
  // A full queue still accepts an arrival when the head leaves in the same cycle.
  assign push             = arrival & ~(bypass & wb_ready) & (~fifo_full | pop);

  always_comb begin
    ovf_err_d     = ovf_err_q | (arrival & fifo_full & ~pop & ~flush);
    issue_stall_d = (int'(count_next) + $countones(vld_d)) >= DEPTH;
  end

  simd_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_data  ({arr_tag, arr_res}),
    .head       (head),
    .count      (count),
    .count_next (count_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q         <= '0;
      issue_stall_q <= 1'b0;
      ovf_err_q     <= 1'b0;
    end else begin
      vld_q         <= vld_d;
      issue_stall_q <= issue_stall_d;
      ovf_err_q     <= ovf_err_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign issue_stall = issue_stall_q;
  assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_simd_wb_queue.sv
// Directed bench for simd_wb_queue: single op, back-pressure, drain order, overflow, flush and reset.
module tb_simd_wb_queue;
  import simd_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_en;
  logic [8:0]  issue_tag;
  logic        issue_stall;
  logic [67:0] simd_res;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [8:0]  wb_tag;
  logic [67:0] wb_data;
  logic        ovf_err;

  int errors = 0;
  int checks = 0;
  int issued;

  logic        pipe_v [2];
  logic [67:0] pipe_d [2];
  logic [67:0] pend_data;
  logic [76:0] exp_q [$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  simd_wb_queue dut (
    .clk         (clk),
    .rst         (rst),
    .issue_en    (issue_en),
    .issue_tag   (issue_tag),
    .issue_stall (issue_stall),
    .simd_res    (simd_res),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .ovf_err     (ovf_err)
  );

  function automatic logic [67:0] mk(input logic [8:0] t);
    simd_res_t r;
    r.ptype = t[1:0];
    r.pad1  = t[0];
    r.hi    = 32'hC0DE_0000 | 32'(t);
    r.pad0  = ~t[0];
    r.lo    = 32'h0000_BEEF ^ 32'(t);
    return r;
  endfunction

  task automatic chk(input string name, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // driver tasks: inputs for the current cycle, then the SIMD unit's result if one is due
  task automatic drive(input logic en, input logic [8:0] tag, input logic [67:0] data,
                       input logic rdy, input logic fl);
    issue_en  = en;
    issue_tag = tag;
    pend_data = data;
    wb_ready  = rdy;
    flush     = fl;
    simd_res  = pipe_v[1] ? pipe_d[1] : 68'hz;
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 9'h0, 68'h0, rdy, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    pipe_v[1] = pipe_v[0];
    pipe_d[1] = pipe_d[0];
    pipe_v[0] = issue_en;
    pipe_d[0] = pend_data;
    #1;
  endtask

  task automatic fill(input logic [8:0] base);
    issued = 0;
    for (int c = 0; c < 8; c++) begin
      if (!issue_stall) begin
        drive(1'b1, base + 9'(issued), mk(base + 9'(issued)), 1'b0, 1'b0);
        issued++;
      end else begin
        idle(1'b0);
      end
      tick();
    end
  endtask

  task automatic drain(input int n);
    logic [76:0] e;
    for (int i = 0; i < n; i++) begin
      idle(1'b1);
      e = exp_q.pop_front();
      chk("drain_valid", 80'(wb_valid), 80'(1'b1));
      chk("drain_tag", 80'(wb_tag), 80'(e[76:68]));
      chk("drain_data", 80'(wb_data), 80'(e[67:0]));
      tick();
    end
  endtask

  logic stall_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    pipe_v[0] = 1'b0; pipe_v[1] = 1'b0;
    pipe_d[0] = '0;   pipe_d[1] = '0;
    rst = 1'b1;
    idle(1'b0); tick();
    idle(1'b0); tick();
    rst = 1'b0;

    // reset state
    idle(1'b0);
    chk("rst_wb_valid", 80'(wb_valid), 80'(1'b0));
    chk("rst_issue_stall", 80'(issue_stall), 80'(1'b0));
    chk("rst_ovf_err", 80'(ovf_err), 80'(1'b0));

    // 1: single op
    drive(1'b1, 9'h005, 68'h0_0000_0001_0000_0002, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    chk("t1_c1_valid", 80'(wb_valid), 80'(1'b0));
    tick();
    idle(1'b1);
`ifdef SIMD_WB_BYPASS_EN
    chk("t1_byp_valid", 80'(wb_valid), 80'(1'b1));
    chk("t1_byp_tag", 80'(wb_tag), 80'(9'h005));
    chk("t1_byp_data", 80'(wb_data), 80'(68'h0_0000_0001_0000_0002));
    tick();
    idle(1'b1);
    chk("t1_after_valid", 80'(wb_valid), 80'(1'b0));
`else
    chk("t1_c2_valid", 80'(wb_valid), 80'(1'b0));
    tick();
    idle(1'b1);
    chk("t1_c3_valid", 80'(wb_valid), 80'(1'b1));
    chk("t1_c3_tag", 80'(wb_tag), 80'(9'h005));
    chk("t1_c3_data", 80'(wb_data), 80'(68'h0_0000_0001_0000_0002));
    tick();
    idle(1'b1);
    chk("t1_c4_valid", 80'(wb_valid), 80'(1'b0));
`endif
    tick();

    // 2: back-pressure with wb_ready low, tags 1..4
    issued = 0;
    for (int c = 0; c < 8; c++) begin
      chk("t2_stall", 80'(issue_stall), 80'(stall_exp[c]));
      if (!issue_stall) begin
        drive(1'b1, 9'(1 + issued), mk(9'(1 + issued)), 1'b0, 1'b0);
        issued++;
      end else begin
        idle(1'b0);
      end
      tick();
    end
    idle(1'b0);
    chk("t2_issued", 80'(issued), 80'(4));
    chk("t2_valid", 80'(wb_valid), 80'(1'b1));
    chk("t2_ovf", 80'(ovf_err), 80'(1'b0));

    // 3: drain order across the pointer wrap
    for (int t = 1; t <= 4; t++) exp_q.push_back({9'(t), mk(9'(t))});
    drain(4);
    idle(1'b0);
    chk("t3_empty_valid", 80'(wb_valid), 80'(1'b0));
    chk("t3_empty_stall", 80'(issue_stall), 80'(1'b0));

    // 4: arrival at full with and without a same-cycle pop
    fill(9'h021);
    idle(1'b0);
    chk("t4_fill_issued", 80'(issued), 80'(4));
    chk("t4_full_stall", 80'(issue_stall), 80'(1'b1));
    drive(1'b1, 9'h025, mk(9'h025), 1'b0, 1'b0); tick();
    idle(1'b0); tick();
    idle(1'b1);
    chk("t4_pop_tag", 80'(wb_tag), 80'(9'h021));
    tick();
    drive(1'b1, 9'h026, mk(9'h026), 1'b0, 1'b0);
    chk("t4_swap_ovf", 80'(ovf_err), 80'(1'b0));
    chk("t4_swap_head", 80'(wb_tag), 80'(9'h022));
    chk("t4_swap_stall", 80'(issue_stall), 80'(1'b1));
    tick();
    idle(1'b0); tick();
    idle(1'b0);
    chk("t4_drop_pre_ovf", 80'(ovf_err), 80'(1'b0));
    tick();
    idle(1'b0);
    chk("t4_drop_ovf", 80'(ovf_err), 80'(1'b1));
    for (int t = 'h22; t <= 'h25; t++) exp_q.push_back({9'(t), mk(9'(t))});
    drain(4);
    idle(1'b0);
    chk("t4_after_valid", 80'(wb_valid), 80'(1'b0));
    chk("t4_sticky_ovf", 80'(ovf_err), 80'(1'b1));

    // 5: flush with two queued and two in flight
    for (int t = 'h31; t <= 'h34; t++) begin
      drive(1'b1, 9'(t), mk(9'(t)), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 9'h035, mk(9'h035), 1'b0, 1'b1);
    chk("t5_pre_valid", 80'(wb_valid), 80'(1'b1));
    chk("t5_pre_stall", 80'(issue_stall), 80'(1'b1));
    tick();
    idle(1'b0);
    chk("t5_post_valid", 80'(wb_valid), 80'(1'b0));
    chk("t5_post_stall", 80'(issue_stall), 80'(1'b0));
    chk("t5_post_ovf", 80'(ovf_err), 80'(1'b1));
    tick();
    idle(1'b0);
    chk("t5_late1_valid", 80'(wb_valid), 80'(1'b0));
    tick();
    idle(1'b0);
    chk("t5_late2_valid", 80'(wb_valid), 80'(1'b0));
    chk("t5_late2_stall", 80'(issue_stall), 80'(1'b0));
    tick();

    // 6: reset mid-stream with ovf_err set
    for (int t = 'h41; t <= 'h43; t++) begin
      drive(1'b1, 9'(t), mk(9'(t)), 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    idle(1'b0);
    chk("t6_pre_valid", 80'(wb_valid), 80'(1'b1));
    chk("t6_pre_ovf", 80'(ovf_err), 80'(1'b1));
    tick();
    rst = 1'b0;
    idle(1'b0);
    chk("t6_valid", 80'(wb_valid), 80'(1'b0));
    chk("t6_stall", 80'(issue_stall), 80'(1'b0));
    chk("t6_ovf", 80'(ovf_err), 80'(1'b0));
    tick();
    idle(1'b0);
    chk("t6_late_valid", 80'(wb_valid), 80'(1'b0));
    tick();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
